neuron_pool: RTL and testbench

NEURON_POOL -- requirements
Module: neuron_pool

---
 rtl/neuron_pool.sv | 137 +++++++++++++
 tb/tb_neuron_pool.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_pool.sv
// Time-multiplexed pool of 128 leaky integrate-and-fire neurons sharing one v/r state memory.
// Latency: two enabled cycles per neuron (LOAD, UPDATE); a full sweep takes 256 enabled cycles.
// Backpressure: en=0 freezes phase, index and memory; spike_out and sweep_done stay low.
module neuron_pool #(
  parameter logic signed [31:0] V_TH       = 32'sd20480,
  parameter logic signed [31:0] V_RESET    = 32'sd0,
  parameter int                 LEAK_SHIFT = 4,
  parameter logic [3:0]         REFRAC     = 4'd3
) (
  input  logic               clk,
  input  logic               reset_bar,
  input  logic               en,
  input  logic signed [31:0] I_in,
  output logic               i_req,
  output logic [6:0]         neuron_index,
  output logic               spike_out,
  output logic [6:0]         spike_index,
  output logic signed [31:0] v_out,
  output logic [7:0]         spike_count,
  output logic               sweep_done
);

  typedef enum logic {LOAD = 1'b0, UPDATE = 1'b1} phase_e;

  phase_e phase_q, phase_d;

  logic [6:0]         idx_q;
  logic               first_q;
  logic [7:0]         acc_q;
  logic signed [31:0] v_rd_q;
  logic [3:0]         r_rd_q;
  logic               spike_q;
  logic [6:0]         spike_idx_q;
  logic signed [31:0] v_out_q;
  logic [7:0]         spike_cnt_q;
  logic               done_q;

  logic signed [31:0] v_mem [128];
  logic [3:0]         r_mem [128];

  logic signed [31:0] leak;
  logic signed [32:0] sum;
  logic signed [31:0] v_sat;
  logic               fire;
  logic signed [31:0] v_wr;
  logic [3:0]         r_wr;
  logic               upd;

  // Phase state register.
  always_ff @(posedge clk) begin
    if (!reset_bar) phase_q <= LOAD;
    else            phase_q <= phase_d;
  end

  // Next phase: alternate LOAD/UPDATE on every enabled edge.
  always_comb begin
    phase_d = phase_q;
    if (en) phase_d = (phase_q == LOAD) ? UPDATE : LOAD;
  end

  // Neuron update datapath: leak, integrate in 33 bits, saturate, threshold.
  always_comb begin
    leak  = v_rd_q >>> LEAK_SHIFT;
    sum   = $signed({v_rd_q[31], v_rd_q}) - $signed({leak[31], leak})
          + $signed({I_in[31], I_in});
    v_sat = sum[31:0];
    if (sum[32] != sum[31]) v_sat = sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    fire  = (r_rd_q == 4'd0) && (v_sat >= V_TH);
    v_wr  = v_sat;
    r_wr  = 4'd0;
    if (r_rd_q != 4'd0) begin
      v_wr = V_RESET;
      r_wr = r_rd_q - 4'd1;
    end else if (fire) begin
      v_wr = V_RESET;
      r_wr = REFRAC;
    end
    upd = en && (phase_q == UPDATE);
  end

  // State memory write-back; an in-flight neuron is dropped if reset hits.
  always_ff @(posedge clk) begin
    if (reset_bar && upd) begin
      v_mem[idx_q] <= v_wr;
      r_mem[idx_q] <= r_wr;
    end
  end

  // Schedule, read staging, spike/sweep bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      idx_q       <= 7'd0;
      first_q     <= 1'b1;
      acc_q       <= 8'd0;
      v_rd_q      <= V_RESET;
      r_rd_q      <= 4'd0;
      spike_q     <= 1'b0;
      spike_idx_q <= 7'd0;
      v_out_q     <= 32'sd0;
      spike_cnt_q <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      spike_q <= 1'b0;
      done_q  <= 1'b0;
      if (en && phase_q == LOAD) begin
        // First sweep after reset ignores whatever the memory holds.
        v_rd_q <= first_q ? V_RESET : v_mem[idx_q];
        r_rd_q <= first_q ? 4'd0    : r_mem[idx_q];
      end
      if (upd) begin
        idx_q <= 7'(idx_q + 7'd1);
        if (fire) begin
          spike_q     <= 1'b1;
          spike_idx_q <= idx_q;
        end
        if (idx_q == 7'd127) begin
          spike_cnt_q <= acc_q + {7'd0, fire};
          v_out_q     <= v_wr;
          done_q      <= 1'b1;
          acc_q       <= 8'd0;
          first_q     <= 1'b0;
        end else begin
          acc_q <= acc_q + {7'd0, fire};
        end
      end
    end
  end

  assign i_req        = (phase_q == UPDATE);
  assign neuron_index = idx_q;
  assign spike_out    = spike_q;
  assign spike_index  = spike_idx_q;
  assign v_out        = v_out_q;
  assign spike_count  = spike_cnt_q;
  assign sweep_done   = done_q;

endmodule

// File: tb/tb_neuron_pool.sv
// Bench for neuron_pool: behavioural model of the pool plus directed scenarios.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: en is dropped for ten cycles mid-sweep in one scenario.
module tb_neuron_pool;

  localparam longint VTH  = 20480;
  localparam longint VRST = 0;
  localparam int     LSH  = 4;
  localparam int     RFR  = 3;

  logic               clk = 1'b0;
  logic               reset_bar = 1'b0;
  logic               en = 1'b0;
  logic signed [31:0] I_in = '0;
  logic               i_req;
  logic [6:0]         neuron_index;
  logic               spike_out;
  logic [6:0]         spike_index;
  logic signed [31:0] v_out;
  logic [7:0]         spike_count;
  logic               sweep_done;

  neuron_pool dut (
    .clk(clk), .reset_bar(reset_bar), .en(en), .I_in(I_in),
    .i_req(i_req), .neuron_index(neuron_index), .spike_out(spike_out),
    .spike_index(spike_index), .v_out(v_out), .spike_count(spike_count),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: enabled-cycle position within a sweep, per-neuron v and r.
  int     cyc = 0;
  bit     first = 1'b1;
  int     acc = 0;
  longint mv [128];
  int     mr [128];
  bit     e_spk = 0;
  int     e_sidx = 0;
  longint e_vout = 0;
  int     e_cnt = 0;
  bit     e_done = 0;

  function automatic logic signed [31:0] stim(input int mode, input int idx);
    case (mode)
      1:       return (idx == 5) ? 32'sd20480 : 32'sd0;
      2:       return 32'sd10240;
      3:       return 32'sd20480;
      4:       return 32'sh8000_0000;
      5:       return 32'sh7FFF_FFFF;
      default: return 32'sd0;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit e, input logic signed [31:0] cur);
    int idx;
    longint v, vn;
    int r;
    if (!rst_n) begin
      cyc = 0; first = 1; acc = 0;
      e_spk = 0; e_sidx = 0; e_vout = 0; e_cnt = 0; e_done = 0;
      return;
    end
    e_spk = 0;
    e_done = 0;
    if (!e) return;
    if (cyc % 2 == 1) begin
      idx = (cyc / 2) % 128;
      v = first ? VRST : mv[idx];
      r = first ? 0 : mr[idx];
      if (r > 0) begin
        mv[idx] = VRST; mr[idx] = r - 1;
      end else begin
        vn = v - (v >>> LSH) + longint'(cur);
        if (vn > 64'sd2147483647)  vn = 64'sd2147483647;
        if (vn < -64'sd2147483648) vn = -64'sd2147483648;
        if (vn >= VTH) begin
          mv[idx] = VRST; mr[idx] = RFR;
          e_spk = 1; e_sidx = idx; acc++;
        end else begin
          mv[idx] = vn; mr[idx] = 0;
        end
      end
      if (idx == 127) begin
        e_cnt = acc; e_vout = mv[idx]; e_done = 1; acc = 0; first = 0;
      end
    end
    cyc = (cyc + 1) % 256;
  endtask

  task automatic compare();
    chk("neuron_index", longint'(neuron_index), longint'((cyc / 2) % 128));
    chk("i_req",        longint'(i_req),        longint'(cyc % 2));
    chk("spike_out",    longint'(spike_out),    longint'(e_spk));
    chk("spike_index",  longint'(spike_index),  longint'(e_sidx));
    chk("v_out",        longint'(v_out),        e_vout);
    chk("spike_count",  longint'(spike_count),  longint'(e_cnt));
    chk("sweep_done",   longint'(sweep_done),   longint'(e_done));
  endtask

  task automatic step(input bit rst_n, input bit e, input int mode);
    logic signed [31:0] cur;
    cur = stim(mode, (cyc / 2) % 128);
    reset_bar = rst_n;
    en = e;
    I_in = cur;
    @(posedge clk);
    model_edge(rst_n, e, cur);
    #1;
    compare();
  endtask

  // Runs one sweep; returns steps taken, DUT spike pulses seen and last spike index.
  task automatic run_sweep(input int mode, input int hold_idx,
                           output int nsteps, output int nspk, output int lastidx);
    bit held;
    held = 0; nsteps = 0; nspk = 0; lastidx = -1;
    for (int g = 0; g < 600; g++) begin
      if (hold_idx >= 0 && !held && cyc == 2 * hold_idx + 1) begin
        repeat (10) step(1, 0, mode);
        held = 1;
      end
      step(1, 1, mode);
      nsteps++;
      if (spike_out) begin nspk++; lastidx = int'(spike_index); end
      if (e_done) break;
    end
    if (!e_done) chk("sweep_timeout", 0, 1);
  endtask

  int ns, nk, li;
  int exp_cnt [5] = '{1, 0, 0, 0, 1};

  initial begin
    // Reset held with en=1 and maximal current: everything stays cleared.
    repeat (5) step(0, 1, 5);
    chk("rst_index", longint'(neuron_index), 0);
    chk("rst_ireq",  longint'(i_req), 0);
    chk("rst_vout",  longint'(v_out), 0);
    chk("rst_count", longint'(spike_count), 0);

    // Zero current: silent sweeps of exactly 256 cycles.
    for (int s = 0; s < 3; s++) begin
      run_sweep(0, -1, ns, nk, li);
      chk("zero_len", ns, 256);
      chk("zero_spk", nk, 0);
      chk("zero_vout", longint'(v_out), 0);
      chk("zero_cnt", longint'(spike_count), 0);
    end

    // Current only into neuron 5: spike, three refractory sweeps, spike again.
    step(0, 1, 0);
    for (int s = 0; s < 5; s++) begin
      run_sweep(1, -1, ns, nk, li);
      chk("n5_cnt", longint'(spike_count), exp_cnt[s]);
      if (exp_cnt[s] == 1) chk("n5_idx", li, 5);
    end

    // Half-threshold current everywhere: fires on the third sweep.
    step(0, 1, 0);
    run_sweep(2, -1, ns, nk, li);
    chk("half_v0", longint'(v_out), 10240);
    run_sweep(2, -1, ns, nk, li);
    chk("half_v1", longint'(v_out), 19840);
    chk("half_c1", longint'(spike_count), 0);
    run_sweep(2, -1, ns, nk, li);
    chk("half_c2", longint'(spike_count), 128);
    chk("half_n2", nk, 128);

    // Enable dropped during UPDATE of neuron 64.
    step(0, 1, 0);
    run_sweep(3, 64, ns, nk, li);
    chk("stall_cnt", longint'(spike_count), 128);
    chk("stall_pulses", nk, 128);
    chk("stall_len", ns, 256);

    // Most negative current saturates rather than wrapping.
    step(0, 1, 0);
    for (int s = 0; s < 2; s++) begin
      run_sweep(4, -1, ns, nk, li);
      chk("sat_vout", longint'(v_out), -64'sd2147483648);
      chk("sat_cnt", longint'(spike_count), 0);
    end
    for (int g = 0; g < 300 && cyc != 141; g++) step(1, 1, 4);
    chk("pre_rst_idx", longint'(neuron_index), 70);
    step(0, 1, 4);
    step(0, 1, 4);
    chk("mid_rst_idx", longint'(neuron_index), 0);
    chk("mid_rst_vout", longint'(v_out), 0);
    // First sweep after reset must ignore the saturated memory contents.
    run_sweep(0, -1, ns, nk, li);
    chk("post_rst_vout", longint'(v_out), 0);
    chk("post_rst_len", ns, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
